// File: rtl/par_to_serial_tx.sv
// par_to_serial_tx: MSB-first byte serialiser on clk_32f; COM sync after reset, then valid/ready data with COM fill.
// Latency: accept to bit 7 on data_out is 2..9 cycles, depending on the bit counter phase.
// Backpressure: one-byte hold register; ready_out low while it is full except at the byte boundary. Option: TX_UNDERRUN_CNT_EN.
module par_to_serial_tx #(
    parameter logic [7:0]  COM_CHAR  = 8'hBC,
    parameter int unsigned SYNC_COMS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_start,
    output logic       active
`ifdef TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0] underrun_cnt
`endif
);

    typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMS - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt;
    logic [7:0] cur_byte;
    logic [7:0] hold;
    logic       hold_valid;
    logic [3:0] com_cnt;
    logic       boundary;
    logic       accept;
    logic       load_hold;
    logic       load_com;
    logic       inc_com;

    assign boundary = (cnt == 3'd7);
    assign active   = (state_q == ST_ACTIVE);
    assign accept   = valid_in & ready_out;

    // State register
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SYNC on the boundary that completes the last COM
    always_comb begin
        state_d = state_q;
        if (state_q == ST_SYNC && boundary && com_cnt == SYNC_LAST) begin
            state_d = ST_ACTIVE;
        end
    end

    // Output / control decode
    always_comb begin
        ready_out = 1'b0;
        load_hold = 1'b0;
        load_com  = 1'b0;
        inc_com   = 1'b0;
        if (state_q == ST_ACTIVE) begin
            ready_out = ~hold_valid | boundary;
            load_hold = boundary & hold_valid;
            load_com  = boundary & ~hold_valid;
        end else begin
            load_com  = boundary;
            inc_com   = boundary;
        end
    end

    // Serial datapath and hold register
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            cnt        <= 3'd0;
            cur_byte   <= COM_CHAR;
            hold       <= 8'd0;
            hold_valid <= 1'b0;
            com_cnt    <= 4'd0;
            data_out   <= 1'b0;
            byte_start <= 1'b0;
        end else begin
            data_out   <= cur_byte[3'd7 - cnt];
            byte_start <= (cnt == 3'd0);
            cnt        <= cnt + 3'd1;
            if (inc_com) begin
                com_cnt <= com_cnt + 4'd1;
            end
            if (load_hold) begin
                cur_byte   <= hold;
                hold_valid <= 1'b0;
            end else if (load_com) begin
                cur_byte <= COM_CHAR;
            end
            // A same-edge accept refills the hold register after it drained into cur_byte
            if (accept) begin
                hold       <= data_in;
                hold_valid <= 1'b1;
            end
        end
    end

`ifdef TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= 8'd0;
        end else if (active && load_com && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_par_to_serial_tx.sv
// Directed bench for par_to_serial_tx: sync sequence, single sends at several bit phases,
// back-to-back streaming, boundary accept with full hold, mid-byte reset and optional underrun counter.
module tb_par_to_serial_tx;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       byte_start;
    logic       active;
`ifdef TX_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt;
`endif

    int errors;
    int checks;
    int edge_n;

    par_to_serial_tx #(.COM_CHAR(8'hBC), .SYNC_COMS(4)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .byte_start (byte_start),
        .active     (active)
`ifdef TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  din;
        int unsigned ph;
        logic [7:0]  slot1;
        logic [7:0]  slot2;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk_32f);
        @(negedge clk_32f);
        edge_n++;
    endtask

    function automatic int cur_cnt();
        return edge_n % 8;
    endfunction

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 8 && cur_cnt() != c; i++) step();
        chk("wait_cnt_phase", cur_cnt(), c);
    endtask

    task automatic get_slot(output logic [7:0] b);
        b = 8'd0;
        wait_cnt(0);
        for (int i = 0; i < 8; i++) begin
            step();
            b[7-i] = data_out;
            chk("slot_byte_start", byte_start, (i == 0) ? 1 : 0);
        end
    endtask

    task automatic present(input logic [7:0] d, input logic exp_rdy, input string name);
        data_in  = d;
        valid_in = 1'b1;
        chk(name, ready_out, exp_rdy);
        step();
        valid_in = 1'b0;
    endtask

    task automatic check_sync();
        logic [7:0] com_v;
        com_v = COM;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("sync_data_out", data_out, com_v[7 - ((k - 1) % 8)]);
            chk("sync_byte_start", byte_start, ((k - 1) % 8 == 0) ? 1 : 0);
            chk("sync_active", active, (k == 32) ? 1 : 0);
            chk("sync_ready_out", ready_out, (k == 32) ? 1 : 0);
`ifdef TX_UNDERRUN_CNT_EN
            chk("sync_underrun_cnt", underrun_cnt, 0);
`endif
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_byte_start", byte_start, 0);
        chk("rst_active", active, 0);
        chk("rst_ready_out", ready_out, 0);
`ifdef TX_UNDERRUN_CNT_EN
        chk("rst_underrun_cnt", underrun_cnt, 0);
`endif
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [39:0] stream;
        logic [7:0]  d3 [3];
        int          sent;

        errors   = 0;
        checks   = 0;
        edge_n   = 0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        vecs[0] = '{din: 8'hA5, ph: 3, slot1: 8'hA5, slot2: COM};
        vecs[1] = '{din: 8'h5A, ph: 0, slot1: 8'h5A, slot2: COM};
        vecs[2] = '{din: 8'h81, ph: 6, slot1: 8'h81, slot2: COM};
        vecs[3] = '{din: 8'h7E, ph: 7, slot1: COM,   slot2: 8'h7E};

        @(negedge clk_32f);
        do_reset();
        check_sync();

        // Single sends at different bit phases, hold empty
        for (int v = 0; v < 4; v++) begin
            wait_cnt(int'(vecs[v].ph));
            present(vecs[v].din, 1'b1, "vec_ready_out");
            get_slot(b);
            chk("vec_slot1", b, vecs[v].slot1);
            get_slot(b);
            chk("vec_slot2", b, vecs[v].slot2);
        end

        // Back-to-back stream with valid_in held high
        wait_cnt(0);
        d3[0] = 8'h01; d3[1] = 8'h02; d3[2] = 8'h03;
        sent   = 0;
        stream = '0;
        for (int i = 0; i < 40; i++) begin
            logic acc;
            if (sent < 3) begin
                data_in  = d3[sent];
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            if (i <= 15) chk("stream_ready_out", ready_out, (i == 0 || i % 8 == 7) ? 1 : 0);
            acc = valid_in & ready_out;
            step();
            if (acc) sent++;
            stream[39 - i] = data_out;
        end
        valid_in = 1'b0;
        chk("stream_sent", sent, 3);
        chk("stream_byte0", stream[39:32], COM);
        chk("stream_byte1", stream[31:24], 8'h01);
        chk("stream_byte2", stream[23:16], 8'h02);
        chk("stream_byte3", stream[15:8],  8'h03);
        chk("stream_byte4", stream[7:0],   COM);

        // Accept at the boundary with the hold register full
        wait_cnt(2);
        present(8'h3C, 1'b1, "full_first_ready");
        for (int c = 3; c < 7; c++) begin
            chk("full_hold_ready", ready_out, 0);
            step();
        end
        chk("full_boundary_phase", cur_cnt(), 7);
        present(8'hC3, 1'b1, "full_boundary_ready");
        chk("full_after_ready", ready_out, 0);
        get_slot(b);
        chk("full_slot_3c", b, 8'h3C);
        get_slot(b);
        chk("full_slot_c3", b, 8'hC3);
        get_slot(b);
        chk("full_slot_com", b, COM);

        // Reset in the middle of a data byte
        wait_cnt(0);
        present(8'h99, 1'b1, "mid_ready");
        wait_cnt(0);
        wait_cnt(4);
        chk("mid_data_bit4", data_out, 1);
        do_reset();
        check_sync();

`ifdef TX_UNDERRUN_CNT_EN
        for (int i = 0; i < 24; i++) step();
        chk("underrun_3", underrun_cnt, 3);
        for (int i = 0; i < 2400; i++) step();
        chk("underrun_sat", underrun_cnt, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
